sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Avalon memory-mapped VGA peripheral that composites `NUM_SPRITES` solid square sprites over a programmable background colour at 640x480, driven from a 50 MHz clock. Sprite registers are double-buffered and committed once per frame at the start of vertical blanking, so software updates never tear. Optional per-sprite sticky collision flags are readable back over the bus. It replaces the single fixed-column player sprite peripheral and sits between the HPS bridge and the VGA DAC pins.

## Interface
Parameters:
- `NUM_SPRITES`, 4: number of sprites, 1..8; index 0 is drawn frontmost.
- `SPRITE_SIZE`, 16: sprite edge length in pixels, 1..64.
- `ADDR_W`, 5: Avalon word-address width; must satisfy 2^ADDR_W >= 4 + 4*NUM_SPRITES.

Ports:
- `clk`  in  1  50 MHz clock.
- `reset`  in  1  synchronous, active-high reset.
- `writedata`  in  16  bus write data.
- `write`  in  1  write strobe.
- `read`  in  1  read strobe.
- `chipselect`  in  1  peripheral select.
- `address`  in  ADDR_W  word address.
- `readdata`  out  16  read data, valid one cycle after the read.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  pixel colour.
- `VGA_CLK`, `VGA_HS`, `VGA_VS`, `VGA_BLANK_n`, `VGA_SYNC_n`  out  1 each  VGA control signals.

## Operation
- Register map (word address):
  - 0, 1, 2: `bg_r`, `bg_g`, `bg_b` in bits [7:0].
  - 3: control. Write bit0 is the global sprite enable. Read returns {frame_count[14:0], enable}.
  - For sprite i at base 4+4i: +0 is x [9:0], +1 is y [9:0], +2 is colour RGB565, +3 is flags (write bit0 = enable; read {7'b0, collide[i], 7'b0, enable}).
- Writes to sprite registers land in the shadow copy. Background and control registers take effect immediately.
- Commit: on the cycle where hcount==1599 and vcount==479, all shadow sprite registers are copied to the active set and `frame_count` increments (wraps at 2^15). A write in the commit cycle updates the shadow only; the commit copies the pre-write value, so the new value appears one frame later.
- Timing generator:
  - hcount counts 0..1599 and vcount 0..524, both synchronously reset to 0.
  - Pixel column is hcount[10:1].
  - HS is low for hcount 1312..1503.
  - VS is low for vcount 490..491.
  - BLANK_n is high only for hcount<1280 and vcount<480.
  - SYNC_n is tied to 0.
- Hit test: sprite i covers a pixel when it is active-enabled, the global enable is set, and both of these hold, computed at 11-bit width so there is no wrap:
  - x_i <= col < x_i + SPRITE_SIZE
  - y_i <= vcount < y_i + SPRITE_SIZE

  Sprites partly off-screen are clipped. Sprites with x>=640 or y>=480 are invisible.
- Colour: the lowest-index covering sprite wins. RGB565 expands to 8 bits by MSB replication ({r5,r5[4:2]}, {g6,g6[5:4]}, {b5,b5[4:2]}). With no sprite covering, the background colour is shown. While blanked, the output is 0.
- Reads: `readdata` is registered on `chipselect && read`. Unmapped addresses read 0.

## Timing
- Reset values:
  - RGB outputs 0; HS, VS and VGA_CLK 1 (hcount=0 gives VGA_CLK 0 one cycle later); BLANK_n 0 until the first registered active pixel; readdata 0.
  - bg = (0x00, 0x00, 0x80); global enable 0.
  - All sprites (shadow and active): x=0, y=0, colour 0xFFFF, enable 0.
  - collide 0; frame_count 0.
- Output pipeline is exactly one cycle. RGB, HS, VS, BLANK_n and VGA_CLK (= registered hcount[0]) are all registered from the same counter state, so they stay aligned.
- Register write to bg/control is visible on pixels whose hit test is evaluated in the next cycle.
- Read latency is 1 cycle. Back-to-back reads are supported, one per cycle.
- Reset asserted mid-frame restarts the counters at (0,0) on the next edge and discards pending shadow contents.

## Configuration
- `SPRITE_COLLISION_EN` defined:
  - On any visible pixel covered by two or more sprites, every covering sprite's `collide[i]` sets and stays set.
  - A read of sprite i's flags register returns the flag and clears it.
  - If a set and a clear happen in the same cycle, the set wins (the flag stays 1; the read returns the pre-clear value).
- `SPRITE_COLLISION_EN` undefined: no collision logic; flags bit8 reads 0.

## Test plan
- Reset, then run one frame: HS low for 192 clk per line, VS low for 2 lines, BLANK_n active pixels = 640x480; colour (0,0,0x80) at pixel (0,0).
- Enable global and sprite 0 with x=100, y=50, colour 0xF800, then wait for a commit: pixels (100..115, 50..65) are (0xFF,0,0); pixels (99,50) and (116,50) show background.
- Write sprite 0 x=200 mid-frame: the current frame still draws at x=100; the next frame draws at x=200; frame_count read increments by 1.
- Overlap sprite 0 and sprite 1 (colour 0x001F) at the same position: sprite 0's colour shown. With `SPRITE_COLLISION_EN`, flags reads 0x0101 for both, then a second read returns 0x0001.
- Sprite at x=630, y=475: only the 10x5 on-screen pixels are drawn; no wrap to column 0 or row 0.
- Write to shadow exactly on the commit cycle: the value is not visible in the following frame and is visible in the frame after it.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Avalon-MM slave bus bundle for the sprite compositor (word-addressed, 16-bit data).
interface sprite_compositor_if #(
   parameter int ADDR_W = 5
);
   logic [15:0]       writedata;
   logic              write;
   logic              read;
   logic              chipselect;
   logic [ADDR_W-1:0] address;
   logic [15:0]       readdata;

   modport master (
      output writedata, write, read, chipselect, address,
      input  readdata
   );

   modport slave (
      input  writedata, write, read, chipselect, address,
      output readdata
   );
endinterface

// File: rtl/sprite_compositor.sv
// Avalon-MM VGA compositor: 640x480 timing, solid square sprites over a background, sprite regs committed at vblank.
// Define SPRITE_COLLISION_EN to add sticky per-sprite collision flags that clear when their flags register is read.
module sprite_compositor #(
   parameter int NUM_SPRITES = 4,
   parameter int SPRITE_SIZE = 16,
   parameter int ADDR_W      = 5
) (
   input  logic               clk,
   input  logic               reset,
   sprite_compositor_if.slave avs,
   output logic [7:0]         VGA_R,
   output logic [7:0]         VGA_G,
   output logic [7:0]         VGA_B,
   output logic               VGA_CLK,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK_n,
   output logic               VGA_SYNC_n
);

   localparam logic [10:0] H_LAST   = 11'd1599;
   localparam logic [10:0] H_ACTIVE = 11'd1280;
   localparam logic [10:0] HS_START = 11'd1312;
   localparam logic [10:0] HS_END   = 11'd1503;
   localparam logic [9:0]  V_LAST   = 10'd524;
   localparam logic [9:0]  V_ACTIVE = 10'd480;
   localparam logic [9:0]  V_COMMIT = 10'd479;
   localparam logic [9:0]  VS_START = 10'd490;
   localparam logic [9:0]  VS_END   = 10'd491;
   localparam logic [10:0] SIZE_EXT = 11'(SPRITE_SIZE);

   logic [10:0] r_hcount;
   logic [9:0]  r_vcount;
   logic [7:0]  r_bgR, r_bgG, r_bgB;
   logic        r_enable;
   logic [14:0] r_frameCount;
   logic [15:0] r_readdata;
   logic [7:0]  r_vgaR, r_vgaG, r_vgaB;
   logic        r_vgaClk, r_vgaHs, r_vgaVs, r_vgaBlankN;

   logic [9:0]             r_shX      [NUM_SPRITES];
   logic [9:0]             r_shY      [NUM_SPRITES];
   logic [15:0]            r_shColour [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_shEn;
   logic [9:0]             r_actX      [NUM_SPRITES];
   logic [9:0]             r_actY      [NUM_SPRITES];
   logic [15:0]            r_actColour [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_actEn;

   logic                   w_commit, w_active, w_wr, w_rd, w_sprRange, w_anyHit;
   logic [ADDR_W-1:0]      w_addrOff;
   logic [ADDR_W-3:0]      w_sprIdx;
   logic [1:0]             w_field;
   logic [NUM_SPRITES-1:0] w_sprSel, w_hit, w_collide;
   logic [10:0]            w_col, w_row;
   logic [15:0]            w_winColour, w_rdData;

   assign w_commit   = (r_hcount == H_LAST) && (r_vcount == V_COMMIT);
   assign w_active   = (r_hcount < H_ACTIVE) && (r_vcount < V_ACTIVE);
   assign w_wr       = avs.chipselect && avs.write;
   assign w_rd       = avs.chipselect && avs.read;
   assign w_sprRange = (avs.address >= ADDR_W'(4));
   assign w_addrOff  = avs.address - ADDR_W'(4);
   assign w_sprIdx   = w_addrOff[ADDR_W-1:2];
   assign w_field    = w_addrOff[1:0];

   always_comb begin
      w_sprSel = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         w_sprSel[i] = w_sprRange && (int'(w_sprIdx) == i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else if (r_hcount == H_LAST) begin
         r_hcount <= '0;
         r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
      end else begin
         r_hcount <= r_hcount + 11'd1;
      end
   end

   // Background and global enable bypass the shadow set and act on the very next pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bgR    <= 8'h00;
         r_bgG    <= 8'h00;
         r_bgB    <= 8'h80;
         r_enable <= 1'b0;
      end else if (w_wr && !w_sprRange) begin
         case (avs.address[1:0])
            2'd0:    r_bgR    <= avs.writedata[7:0];
            2'd1:    r_bgG    <= avs.writedata[7:0];
            2'd2:    r_bgB    <= avs.writedata[7:0];
            default: r_enable <= avs.writedata[0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_shX[i]      <= '0;
            r_shY[i]      <= '0;
            r_shColour[i] <= 16'hFFFF;
         end
         r_shEn <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_wr && w_sprSel[i]) begin
               case (w_field)
                  2'd0:    r_shX[i]      <= avs.writedata[9:0];
                  2'd1:    r_shY[i]      <= avs.writedata[9:0];
                  2'd2:    r_shColour[i] <= avs.writedata;
                  default: r_shEn[i]     <= avs.writedata[0];
               endcase
            end
         end
      end
   end

   // Commit copies the pre-write shadow, so a write landing on this edge shows up a frame later.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_actX[i]      <= '0;
            r_actY[i]      <= '0;
            r_actColour[i] <= 16'hFFFF;
         end
         r_actEn      <= '0;
         r_frameCount <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_actX[i]      <= r_shX[i];
            r_actY[i]      <= r_shY[i];
            r_actColour[i] <= r_shColour[i];
         end
         r_actEn      <= r_shEn;
         r_frameCount <= r_frameCount + 15'd1;
      end
   end

   assign w_col = {1'b0, r_hcount[10:1]};
   assign w_row = {1'b0, r_vcount};

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         w_hit[i] = r_enable && r_actEn[i]
                 && ({1'b0, r_actX[i]} <= w_col) && (w_col < {1'b0, r_actX[i]} + SIZE_EXT)
                 && ({1'b0, r_actY[i]} <= w_row) && (w_row < {1'b0, r_actY[i]} + SIZE_EXT);
   end

   always_comb begin
      w_anyHit    = 1'b0;
      w_winColour = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_anyHit    = 1'b1;
            w_winColour = r_actColour[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vgaR      <= '0;
         r_vgaG      <= '0;
         r_vgaB      <= '0;
         r_vgaHs     <= 1'b1;
         r_vgaVs     <= 1'b1;
         r_vgaClk    <= 1'b1;
         r_vgaBlankN <= 1'b0;
      end else begin
         r_vgaHs     <= !((r_hcount >= HS_START) && (r_hcount <= HS_END));
         r_vgaVs     <= !((r_vcount >= VS_START) && (r_vcount <= VS_END));
         r_vgaClk    <= r_hcount[0];
         r_vgaBlankN <= w_active;
         if (!w_active) begin
            r_vgaR <= '0;
            r_vgaG <= '0;
            r_vgaB <= '0;
         end else if (w_anyHit) begin
            r_vgaR <= {w_winColour[15:11], w_winColour[15:13]};
            r_vgaG <= {w_winColour[10:5], w_winColour[10:9]};
            r_vgaB <= {w_winColour[4:0], w_winColour[4:2]};
         end else begin
            r_vgaR <= r_bgR;
            r_vgaG <= r_bgG;
            r_vgaB <= r_bgB;
         end
      end
   end

`ifdef SPRITE_COLLISION_EN
   logic [NUM_SPRITES-1:0] r_collide;
   logic                   w_multiHit;

   assign w_multiHit = (w_hit & (w_hit - NUM_SPRITES'(1))) != '0;

   // A new collision outranks a clear-on-read arriving on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_collide <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_active && w_multiHit && w_hit[i])
               r_collide[i] <= 1'b1;
            else if (w_rd && w_sprSel[i] && (w_field == 2'd3))
               r_collide[i] <= 1'b0;
         end
      end
   end

   assign w_collide = r_collide;
`else
   assign w_collide = '0;
`endif

   always_comb begin
      w_rdData = '0;
      if (!w_sprRange) begin
         case (avs.address[1:0])
            2'd0:    w_rdData = {8'h00, r_bgR};
            2'd1:    w_rdData = {8'h00, r_bgG};
            2'd2:    w_rdData = {8'h00, r_bgB};
            default: w_rdData = {r_frameCount, r_enable};
         endcase
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (w_sprSel[i]) begin
               case (w_field)
                  2'd0:    w_rdData = {6'd0, r_shX[i]};
                  2'd1:    w_rdData = {6'd0, r_shY[i]};
                  2'd2:    w_rdData = r_shColour[i];
                  default: w_rdData = {7'd0, w_collide[i], 7'd0, r_shEn[i]};
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_readdata <= '0;
      else if (w_rd)
         r_readdata <= w_rdData;
   end

   assign avs.readdata = r_readdata;
   assign VGA_R        = r_vgaR;
   assign VGA_G        = r_vgaG;
   assign VGA_B        = r_vgaB;
   assign VGA_CLK      = r_vgaClk;
   assign VGA_HS       = r_vgaHs;
   assign VGA_VS       = r_vgaVs;
   assign VGA_BLANK_n  = r_vgaBlankN;
   assign VGA_SYNC_n   = 1'b0;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: frame timing, commit behaviour, priority, clipping and bus reads.
module tb_sprite_compositor;

   localparam int NUM_SPRITES = 4;
   localparam int SPRITE_SIZE = 16;
   localparam int ADDR_W      = 5;
   localparam int LINE        = 1600;
   localparam int FRAME       = 840000;

`ifdef SPRITE_COLLISION_EN
   localparam logic [15:0] FLAGS_COLLIDED = 16'h0101;
`else
   localparam logic [15:0] FLAGS_COLLIDED = 16'h0001;
`endif

   localparam logic [23:0] BG     = 24'h000080;
   localparam logic [23:0] RED    = 24'hFF0000;
   localparam logic [23:0] YELLOW = 24'hFFFF00;
   localparam logic [23:0] GREEN  = 24'h00FF00;
   localparam logic [23:0] BLUE   = 24'h0000FF;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] vgaR, vgaG, vgaB;
   logic       vgaClk, vgaHs, vgaVs, vgaBlankN, vgaSyncN;
   logic [15:0] rd;

   sprite_compositor_if #(.ADDR_W(ADDR_W)) bus ();

   sprite_compositor #(
      .NUM_SPRITES(NUM_SPRITES),
      .SPRITE_SIZE(SPRITE_SIZE),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .avs(bus),
      .VGA_R(vgaR),
      .VGA_G(vgaG),
      .VGA_B(vgaB),
      .VGA_CLK(vgaClk),
      .VGA_HS(vgaHs),
      .VGA_VS(vgaVs),
      .VGA_BLANK_n(vgaBlankN),
      .VGA_SYNC_n(vgaSyncN)
   );

   always #5 clk = ~clk;

   // edgeCount-1 is the counter index whose pixel the outputs currently show.
   int edgeCount = 0;
   always @(posedge clk) begin
      if (reset) edgeCount <= 0;
      else       edgeCount <= edgeCount + 1;
   end

   int hsLowLine0 = 0, vsLowFrame0 = 0, blankHighFrame0 = 0, rgbDuringBlank = 0;
   always @(negedge clk) begin
      if (!reset && edgeCount >= 1 && edgeCount <= FRAME) begin
         if (edgeCount <= LINE && !vgaHs) hsLowLine0 <= hsLowLine0 + 1;
         if (!vgaVs) vsLowFrame0 <= vsLowFrame0 + 1;
         if (vgaBlankN) blankHighFrame0 <= blankHighFrame0 + 1;
         else if ({vgaR, vgaG, vgaB} != 24'h0) rgbDuringBlank <= rgbDuringBlank + 1;
      end
   end

   int checks = 0, failures = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic isWrite, input int addr, input logic [15:0] data,
                                output logic [15:0] rdata);
      bus.chipselect = 1'b1;
      bus.write      = isWrite;
      bus.read       = !isWrite;
      bus.address    = ADDR_W'(addr);
      bus.writedata  = data;
      @(posedge clk);
      #1;
      rdata          = bus.readdata;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
   endtask

   task automatic waitIndex(input int index);
      if (edgeCount > index + 1) checkOutput("scheduleLate", edgeCount, index + 1);
      while (edgeCount < index + 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int pix(input int frame, input int col, input int row);
      return frame * FRAME + row * LINE + col * 2;
   endfunction

   task automatic checkPixel(input string tag, input int frame, input int col, input int row,
                             input logic [23:0] rgb);
      waitIndex(pix(frame, col, row));
      checkOutput(tag, {vgaR, vgaG, vgaB}, rgb);
   endtask

   initial begin
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;
      reset          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetRgb", {vgaR, vgaG, vgaB}, 24'h0);
      checkOutput("resetCtl", {vgaHs, vgaVs, vgaClk, vgaBlankN, vgaSyncN}, 5'b11100);
      checkOutput("resetReaddata", bus.readdata, 16'h0);
      reset = 1'b0;

      waitIndex(0);
      checkOutput("pixel00", {vgaR, vgaG, vgaB}, BG);
      checkOutput("pixel00Ctl", {vgaHs, vgaVs, vgaClk, vgaBlankN}, 4'b1101);

      applyStimulus(1'b0, 3, 16'h0, rd);  checkOutput("ctrlReset", rd, 16'h0000);
      applyStimulus(1'b0, 2, 16'h0, rd);  checkOutput("bgBReset", rd, 16'h0080);
      applyStimulus(1'b0, 6, 16'h0, rd);  checkOutput("spr0ColourReset", rd, 16'hFFFF);
      applyStimulus(1'b0, 20, 16'h0, rd); checkOutput("unmappedRead", rd, 16'h0000);

      applyStimulus(1'b1, 3, 16'd1, rd);
      applyStimulus(1'b1, 4, 16'd100, rd);
      applyStimulus(1'b1, 5, 16'd50, rd);
      applyStimulus(1'b1, 6, 16'hF800, rd);
      applyStimulus(1'b1, 7, 16'd1, rd);
      applyStimulus(1'b1, 8, 16'd630, rd);
      applyStimulus(1'b1, 9, 16'd475, rd);
      applyStimulus(1'b1, 10, 16'hFFE0, rd);
      applyStimulus(1'b1, 11, 16'd1, rd);
      applyStimulus(1'b1, 12, 16'd300, rd);
      applyStimulus(1'b1, 13, 16'd200, rd);
      applyStimulus(1'b1, 14, 16'h07E0, rd);
      applyStimulus(1'b1, 15, 16'd1, rd);
      applyStimulus(1'b1, 16, 16'd300, rd);
      applyStimulus(1'b1, 17, 16'd200, rd);
      applyStimulus(1'b1, 18, 16'h001F, rd);
      applyStimulus(1'b1, 19, 16'd1, rd);
      applyStimulus(1'b0, 4, 16'h0, rd);  checkOutput("spr0XShadow", rd, 16'd100);
      applyStimulus(1'b0, 3, 16'h0, rd);  checkOutput("ctrlEnabled", rd, 16'h0001);

      waitIndex(1311); checkOutput("hsBeforeSync", vgaHs, 1'b1);
      waitIndex(1312); checkOutput("hsSyncStart", vgaHs, 1'b0);
      waitIndex(1503); checkOutput("hsSyncEnd", vgaHs, 1'b0);
      waitIndex(1504); checkOutput("hsAfterSync", vgaHs, 1'b1);

      // This write is sampled on the commit edge itself (counters at 1599,479).
      waitIndex(479 * LINE + 1599 - 1);
      applyStimulus(1'b1, 6, 16'h001F, rd);

      waitIndex(489 * LINE + 1599); checkOutput("vsBeforeSync", vgaVs, 1'b1);
      waitIndex(490 * LINE);        checkOutput("vsSyncStart", vgaVs, 1'b0);
      waitIndex(492 * LINE);        checkOutput("vsAfterSync", vgaVs, 1'b1);

      waitIndex(FRAME + 10 * LINE);
      applyStimulus(1'b0, 3, 16'h0, rd);  checkOutput("frameCount1", rd, 16'h0003);
      applyStimulus(1'b1, 4, 16'd200, rd);

      checkPixel("s0LeftOut", 1, 99, 50, BG);
      checkPixel("s0TopLeft", 1, 100, 50, RED);
      checkPixel("s0TopRight", 1, 115, 50, RED);
      checkPixel("s0RightOut", 1, 116, 50, BG);
      checkPixel("s0BottomIn", 1, 100, 65, RED);
      checkPixel("s0BelowOut", 1, 100, 66, BG);
      checkPixel("overlapFront", 1, 300, 200, GREEN);
      checkPixel("overlapCorner", 1, 315, 215, GREEN);

      waitIndex(pix(1, 0, 230));
      applyStimulus(1'b0, 15, 16'h0, rd); checkOutput("flagsS2", rd, FLAGS_COLLIDED);
      applyStimulus(1'b0, 19, 16'h0, rd); checkOutput("flagsS3", rd, FLAGS_COLLIDED);
      applyStimulus(1'b0, 15, 16'h0, rd); checkOutput("flagsS2Cleared", rd, 16'h0001);
      applyStimulus(1'b0, 7, 16'h0, rd);  checkOutput("flagsS0", rd, 16'h0001);

      checkPixel("clipLeftOut", 1, 629, 475, BG);
      checkPixel("clipFirst", 1, 630, 475, YELLOW);
      waitIndex(FRAME + 475 * LINE + 1290);
      checkOutput("clipBlankRgb", {vgaR, vgaG, vgaB}, 24'h0);
      checkOutput("clipBlankN", vgaBlankN, 1'b0);
      checkPixel("noWrapCol0", 1, 0, 476, BG);
      checkPixel("clipLast", 1, 639, 479, YELLOW);

      checkPixel("noWrapRow0", 2, 630, 0, BG);
      waitIndex(2 * FRAME + 10 * LINE);
      applyStimulus(1'b0, 3, 16'h0, rd);  checkOutput("frameCount2", rd, 16'h0005);
      checkPixel("oldXGone", 2, 100, 50, BG);
      checkPixel("newXCommitWrite", 2, 200, 50, BLUE);
      checkPixel("newXCorner", 2, 215, 65, BLUE);
      checkPixel("newXRightOut", 2, 216, 65, BG);

      waitIndex(2 * FRAME + 70 * LINE);
      applyStimulus(1'b1, 1, 16'h0040, rd);
      checkPixel("bgGreenWrite", 2, 100, 80, 24'h004080);

      checkOutput("hsLowLine0", hsLowLine0, 192);
      checkOutput("vsLowFrame0", vsLowFrame0, 2 * LINE);
      checkOutput("blankHighFrame0", blankHighFrame0, 1280 * 480);
      checkOutput("rgbDuringBlank", rgbDuringBlank, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
